// File: rtl/proc_simd_sat_alu_pipe.sv
// Packed-SIMD saturating ALU on 8/16/32-bit lanes. Define PROC_SIMD_ALU_SAD_EN for byte-SAD accumulation on ew=11.
// Latency: 2 cycles (accepted in cycle N -> resp_val in N+2), one result per cycle when resp_rdy=1.
// Backpressure: resp_rdy=0 holds S2, then S1; req_rdy drops only when both stages are full and stalled.
module proc_simd_sat_alu_pipe #(
   parameter int p_nbits       = 32,
   parameter int p_ov_set_wins = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_val,
   output logic               req_rdy,
   input  logic [3:0]         req_fn,
   input  logic [1:0]         req_ew,
   input  logic [p_nbits-1:0] req_in0,
   input  logic [p_nbits-1:0] req_in1,
   output logic               resp_val,
   input  logic               resp_rdy,
   output logic [p_nbits-1:0] resp_out,
   output logic               resp_sat,
   input  logic               ov_clr,
   output logic               ov_flag
);

   // One lane of width w (8/16/32); operands arrive zero-extended, result is {sat, lane value}.
   function automatic logic [32:0] lane_op(input logic [3:0] fn, input logic [31:0] a,
                                           input logic [31:0] b, input int w);
      logic signed [63:0] as, bs, s, smax, smin;
      logic [63:0]        ua, ub, u, umask;
      logic [4:0]         sh;
      logic [31:0]        r;
      logic               sat;
      umask = (64'd1 << w) - 64'd1;
      ua    = {32'd0, a} & umask;
      ub    = {32'd0, b} & umask;
      as    = $signed(ua << (64 - w)) >>> (64 - w);
      bs    = $signed(ub << (64 - w)) >>> (64 - w);
      smax  = $signed(umask >> 1);
      smin  = -smax - 64'sd1;
      sh    = 5'(ub) & 5'(w - 1);
      sat   = 1'b0;
      s     = '0;
      u     = '0;
      r     = '0;
      case (fn)
         4'd0:  r = 32'(ua + ub);
         4'd1:  r = 32'(ua - ub);
         4'd2, 4'd3, 4'd15: begin
            if (fn == 4'd2)      s = as + bs;
            else if (fn == 4'd3) s = as - bs;
            else                 s = as <<< sh;
            if (s > smax) begin
               r = 32'(smax); sat = 1'b1;
            end else if (s < smin) begin
               r = 32'(smin); sat = 1'b1;
            end else begin
               r = 32'(s);
            end
         end
         4'd4: begin
            u = ua + ub;
            if (u > umask) begin
               r = umask[31:0]; sat = 1'b1;
            end else begin
               r = 32'(u);
            end
         end
         4'd5: begin
            if (ua < ub) sat = 1'b1;
            else         r = 32'(ua - ub);
         end
         4'd6:  r = 32'((as > bs) ? ua : ub);
         4'd7:  r = 32'((as < bs) ? ua : ub);
         4'd8:  r = 32'((ua > ub) ? ua : ub);
         4'd9:  r = 32'((ua < ub) ? ua : ub);
         4'd10: r = (as < bs) ? umask[31:0] : 32'd0;
         4'd11: r = (ua < ub) ? umask[31:0] : 32'd0;
         4'd12: r = 32'(ua << sh);
         4'd13: r = 32'(ua >> sh);
         default: r = 32'(as >>> sh);
      endcase
      return {sat, r & umask[31:0]};
   endfunction

   logic               s1_val, s2_val, s1_adv, s2_adv;
   logic [3:0]         s1_fn;
   logic [1:0]         s1_ew;
   logic [p_nbits-1:0] s1_in0, s1_in1;
   logic [p_nbits-1:0] s2_out, out8, out16, out32, sp_out, res_out;
   logic               s2_sat, sat8, sat16, sat32, res_sat, ov_set, ov_next;
   logic [32:0]        lane_t;

   assign s2_adv   = !s2_val || resp_rdy;
   assign s1_adv   = !s1_val || s2_adv;
   assign req_rdy  = s1_adv;
   assign resp_val = s2_val;
   assign resp_out = s2_out;
   assign resp_sat = s2_sat;

   always_comb begin
      lane_t = '0;
      out8 = '0; out16 = '0; out32 = '0;
      sat8 = 1'b0; sat16 = 1'b0; sat32 = 1'b0;
      for (int i = 0; i < p_nbits / 8; i++) begin
         lane_t = lane_op(s1_fn, 32'(s1_in0[8*i +: 8]), 32'(s1_in1[8*i +: 8]), 8);
         out8   = out8 | (p_nbits'(lane_t[31:0]) << (8 * i));
         sat8   = sat8 | lane_t[32];
      end
      for (int i = 0; i < p_nbits / 16; i++) begin
         lane_t = lane_op(s1_fn, 32'(s1_in0[16*i +: 16]), 32'(s1_in1[16*i +: 16]), 16);
         out16  = out16 | (p_nbits'(lane_t[31:0]) << (16 * i));
         sat16  = sat16 | lane_t[32];
      end
      for (int i = 0; i < p_nbits / 32; i++) begin
         lane_t = lane_op(s1_fn, s1_in0[32*i +: 32], s1_in1[32*i +: 32], 32);
         out32  = out32 | (p_nbits'(lane_t[31:0]) << (32 * i));
         sat32  = sat32 | lane_t[32];
      end
   end

`ifdef PROC_SIMD_ALU_SAD_EN
   logic [p_nbits-1:0] acc, sad_sum;

   always_comb begin
      sad_sum = '0;
      for (int i = 0; i < p_nbits / 8; i++) begin
         if (s1_in0[8*i +: 8] > s1_in1[8*i +: 8])
            sad_sum = sad_sum + p_nbits'(8'(s1_in0[8*i +: 8] - s1_in1[8*i +: 8]));
         else
            sad_sum = sad_sum + p_nbits'(8'(s1_in1[8*i +: 8] - s1_in0[8*i +: 8]));
      end
      sp_out = (s1_fn[0] ? '0 : acc) + sad_sum;
   end

   // acc follows program order: it only moves when the SAD op leaves S1.
   always_ff @(posedge clk) begin
      if (!reset)
         acc <= '0;
      else if (s1_val && s2_adv && s1_ew == 2'b11)
         acc <= sp_out;
   end
`else
   assign sp_out = '0;
`endif

   always_comb begin
      res_out = sp_out;
      res_sat = 1'b0;
      case (s1_ew)
         2'b00:   begin res_out = out8;  res_sat = sat8;  end
         2'b01:   begin res_out = out16; res_sat = sat16; end
         2'b10:   begin res_out = out32; res_sat = sat32; end
         default: begin res_out = sp_out; res_sat = 1'b0; end
      endcase
   end

   // Only a transferred response counts toward the sticky flag.
   always_comb begin
      ov_set  = s2_val && resp_rdy && s2_sat;
      ov_next = ov_flag;
      if (ov_set && ov_clr) ov_next = (p_ov_set_wins != 0);
      else if (ov_set)      ov_next = 1'b1;
      else if (ov_clr)      ov_next = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_val  <= 1'b0;
         s2_val  <= 1'b0;
         s2_out  <= '0;
         s2_sat  <= 1'b0;
         ov_flag <= 1'b0;
      end else begin
         if (s1_adv) s1_val <= req_val;
         if (s2_adv) s2_val <= s1_val;
         if (s2_adv && s1_val) begin
            s2_out <= res_out;
            s2_sat <= res_sat;
         end
         ov_flag <= ov_next;
      end
   end

   always_ff @(posedge clk) begin
      if (req_val && req_rdy) begin
         s1_fn  <= req_fn;
         s1_ew  <= req_ew;
         s1_in0 <= req_in0;
         s1_in1 <= req_in1;
      end
   end

endmodule

// File: tb/tb_proc_simd_sat_alu_pipe.sv
// Randomized and directed bench for proc_simd_sat_alu_pipe (p_nbits=32) against a lane-arithmetic reference model.
module tb_proc_simd_sat_alu_pipe;
   localparam int SET_WINS = 1;

   logic        clk = 1'b0;
   logic        reset, req_val, req_rdy, resp_val, resp_rdy, resp_sat, ov_clr, ov_flag;
   logic [3:0]  req_fn;
   logic [1:0]  req_ew;
   logic [31:0] req_in0, req_in1, resp_out;

   proc_simd_sat_alu_pipe #(.p_nbits(32), .p_ov_set_wins(SET_WINS)) dut (
      .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy), .req_fn(req_fn),
      .req_ew(req_ew), .req_in0(req_in0), .req_in1(req_in1), .resp_val(resp_val),
      .resp_rdy(resp_rdy), .resp_out(resp_out), .resp_sat(resp_sat), .ov_clr(ov_clr),
      .ov_flag(ov_flag));

   always #5 clk = ~clk;

   typedef struct {logic [3:0] fn; logic [1:0] ew; logic [31:0] a, b, out; logic sat;} stim_t;
   typedef struct {int acc; logic [31:0] out; logic sat;} item_t;

   stim_t       stim[$];
   item_t       q[$];
   int          checks = 0, failures = 0, cyc = 0, last_pop = 0, n_acc = 0, n_pop = 0;
   logic        ov_m = 1'b0, rand_rdy = 1'b0, clr_on_xfer = 1'b0, clr_force = 1'b0;
   int          clr_pct = 0;
   logic [31:0] acc_m = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Lane-by-lane integer reference: values reduced modulo 2^w, saturation by clamping.
   function automatic logic [31:0] ref_alu(input logic [3:0] fn, input logic [1:0] ew,
                                           input logic [31:0] a, input logic [31:0] b,
                                           output logic sat);
      longint w, m, hi, lo, ua, ub, sa, sb, r, p;
      logic [31:0] res;
      res = '0;
      sat = 1'b0;
      if (ew == 2'b11) return res;
      w  = longint'(8) << ew;
      m  = longint'(1) << w;
      hi = m / 2 - 1;
      lo = -(m / 2);
      for (int k = 0; k < 32 / int'(w); k++) begin
         ua = longint'({32'd0, a >> (k * int'(w))}) % m;
         ub = longint'({32'd0, b >> (k * int'(w))}) % m;
         sa = (ua > hi) ? ua - m : ua;
         sb = (ub > hi) ? ub - m : ub;
         p  = longint'(1) << (ub % w);
         case (fn)
            4'd0, 4'd4: r = ua + ub;
            4'd1, 4'd5: r = ua - ub;
            4'd2:  r = sa + sb;
            4'd3:  r = sa - sb;
            4'd6:  r = (sa > sb) ? sa : sb;
            4'd7:  r = (sa < sb) ? sa : sb;
            4'd8:  r = (ua > ub) ? ua : ub;
            4'd9:  r = (ua < ub) ? ua : ub;
            4'd10: r = (sa < sb) ? -1 : 0;
            4'd11: r = (ua < ub) ? -1 : 0;
            4'd12: r = ua * p;
            4'd13: r = ua / p;
            4'd14: r = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
            default: r = sa * p;
         endcase
         if (fn inside {4'd2, 4'd3, 4'd15}) begin
            if (r > hi) begin r = hi; sat = 1'b1; end
            if (r < lo) begin r = lo; sat = 1'b1; end
         end
         if (fn == 4'd4 && r > m - 1) begin r = m - 1; sat = 1'b1; end
         if (fn == 4'd5 && r < 0)     begin r = 0;     sat = 1'b1; end
         r   = ((r % m) + m) % m;
         res = res | (32'(r) << (k * int'(w)));
      end
      return res;
   endfunction

   function automatic logic [31:0] sad4(input logic [31:0] a, input logic [31:0] b);
      int s = 0;
      for (int k = 0; k < 4; k++) begin
         int x = int'(a[8*k +: 8]);
         int y = int'(b[8*k +: 8]);
         s += (x > y) ? x - y : y - x;
      end
      return 32'(s);
   endfunction

   task automatic enq_exp(input logic [3:0] fn, input logic [1:0] ew, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] out, input logic sat);
      stim_t s;
      s.fn = fn; s.ew = ew; s.a = a; s.b = b; s.out = out; s.sat = sat;
      stim.push_back(s);
   endtask

   task automatic enq_model(input logic [3:0] fn, input logic [1:0] ew, input logic [31:0] a,
                            input logic [31:0] b);
      logic [31:0] o;
      logic        st;
      o = ref_alu(fn, ew, a, b, st);
`ifdef PROC_SIMD_ALU_SAD_EN
      if (ew == 2'b11) begin
         acc_m = (fn[0] ? 32'd0 : acc_m) + sad4(a, b);
         o = acc_m;
         st = 1'b0;
      end
`endif
      enq_exp(fn, ew, a, b, o, st);
   endtask

   // One clock: drive, check outputs against the model, update the model, advance.
   task automatic cycle();
      logic val_e, rdy_e, xfer;
      val_e = 1'b0;
      if (q.size() > 0)
         val_e = (cyc >= ((q[0].acc + 2 > last_pop + 1) ? q[0].acc + 2 : last_pop + 1));
      if (rand_rdy) resp_rdy = 1'($urandom_range(0, 1));
      req_val = (stim.size() > 0);
      if (req_val) begin
         req_fn = stim[0].fn; req_ew = stim[0].ew; req_in0 = stim[0].a; req_in1 = stim[0].b;
      end
      ov_clr = clr_force || (clr_on_xfer && val_e && resp_rdy) ||
               ($urandom_range(0, 99) < clr_pct);
      #1;
      rdy_e = !(q.size() == 2 && !resp_rdy);
      chk("req_rdy", 64'(req_rdy), 64'(rdy_e));
      chk("resp_val", 64'(resp_val), 64'(val_e));
      if (val_e && resp_val) begin
         chk("resp_out", 64'(resp_out), 64'(q[0].out));
         chk("resp_sat", 64'(resp_sat), 64'(q[0].sat));
      end
      chk("ov_flag", 64'(ov_flag), 64'(ov_m));
      xfer = val_e && resp_rdy;
      if (xfer && q[0].sat && ov_clr) ov_m = (SET_WINS != 0);
      else if (xfer && q[0].sat)     ov_m = 1'b1;
      else if (ov_clr)               ov_m = 1'b0;
      if (xfer) begin
         void'(q.pop_front());
         last_pop = cyc;
         n_pop++;
      end
      if (req_val && rdy_e) begin
         q.push_back('{cyc, stim[0].out, stim[0].sat});
         void'(stim.pop_front());
         n_acc++;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 400; k++) begin
         if (q.size() + stim.size() == 0) break;
         cycle();
      end
      chk(tag, 64'(q.size() + stim.size()), 64'd0);
   endtask

   task automatic do_reset();
      reset = 1'b0; req_val = 1'b0; ov_clr = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      chk("rst_resp_val", 64'(resp_val), 64'd0);
      chk("rst_resp_out", 64'(resp_out), 64'd0);
      chk("rst_resp_sat", 64'(resp_sat), 64'd0);
      chk("rst_ov_flag", 64'(ov_flag), 64'd0);
      chk("rst_req_rdy", 64'(req_rdy), 64'd1);
      reset = 1'b1;
      q.delete();
      ov_m = 1'b0;
      acc_m = '0;
      last_pop = cyc;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      reset = 1'b0; req_val = 1'b0; req_fn = '0; req_ew = '0; req_in0 = '0; req_in1 = '0;
      resp_rdy = 1'b1; ov_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      enq_exp(4'd2, 2'b00, 32'h7F80_0A01, 32'h01FF_0502, 32'h7F80_0F03, 1'b1);
      drain("drain_kadd8");
      chk("ov_after_kadd8", 64'(ov_flag), 64'd1);

      enq_exp(4'd5, 2'b01, 32'h0005_FFFF, 32'h0006_0001, 32'h0000_FFFE, 1'b1);
      drain("drain_uksub16");
      clr_force = 1'b1;
      cycle();
      clr_force = 1'b0;
      chk("ov_after_clr", 64'(ov_flag), 64'd0);

      clr_on_xfer = 1'b1;
      enq_exp(4'd2, 2'b00, 32'h7F80_0A01, 32'h01FF_0502, 32'h7F80_0F03, 1'b1);
      drain("drain_clr_race");
      clr_on_xfer = 1'b0;
      chk("ov_set_vs_clr", 64'(ov_flag), 64'(SET_WINS != 0));

      enq_exp(4'd14, 2'b00, 32'h80F0_4001, 32'h0701_0200, 32'hFFF8_1001, 1'b0);
      enq_exp(4'd10, 2'b00, 32'hFF01_0080, 32'h0002_0000, 32'hFFFF_00FF, 1'b0);
`ifndef PROC_SIMD_ALU_SAD_EN
      enq_exp(4'd2, 2'b11, 32'h7F7F_7F7F, 32'h7F7F_7F7F, 32'h0, 1'b0);
`endif
      drain("drain_sra_cmplt");

      resp_rdy = 1'b0;
      for (int i = 10; i < 14; i++) enq_exp(4'd0, 2'b10, 32'(i), 32'(i + 1), 32'(2 * i + 1), 1'b0);
      n0 = n_acc;
      repeat (5) cycle();
      chk("bp_accepts", 64'(n_acc - n0), 64'd2);
      chk("bp_req_rdy", 64'(req_rdy), 64'd0);
      resp_rdy = 1'b1;
      n0 = n_pop;
      drain("drain_bp");
      chk("bp_responses", 64'(n_pop - n0), 64'd4);

      rand_rdy = 1'b1;
      clr_pct = 5;
      for (int k = 0; k < 600; k++) begin
         if (stim.size() < 2 && $urandom_range(0, 3) != 0) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'h7F80_7F80 ^ (a & 32'h0101_0101);
            if ($urandom_range(0, 3) == 0) b = 32'h7F80_FF01 ^ (b & 32'h0303_0303);
            enq_model(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), a, b);
         end
         cycle();
      end
      rand_rdy = 1'b0;
      clr_pct = 0;
      resp_rdy = 1'b1;
      drain("drain_random");

      enq_exp(4'd2, 2'b00, 32'h0000_007F, 32'h0000_0001, 32'h0000_007F, 1'b1);
      drain("drain_pre_reset");
      resp_rdy = 1'b0;
      enq_exp(4'd0, 2'b10, 32'd1, 32'd2, 32'd3, 1'b0);
      enq_exp(4'd0, 2'b10, 32'd3, 32'd4, 32'd7, 1'b0);
      for (int k = 0; k < 10 && stim.size() > 0; k++) cycle();
      cycle();
      chk("pre_reset_resp_val", 64'(resp_val), 64'd1);
      chk("pre_reset_ov", 64'(ov_flag), 64'd1);
      do_reset();
      resp_rdy = 1'b1;
      enq_exp(4'd1, 2'b00, 32'h0000_0000, 32'h0101_0101, 32'hFFFF_FFFF, 1'b0);
      drain("drain_post_reset");

`ifdef PROC_SIMD_ALU_SAD_EN
      enq_model(4'd1, 2'b11, 32'h0A00_FF10, 32'h050A_0020);
      enq_model(4'd0, 2'b11, 32'h0A00_FF10, 32'h050A_0020);
      drain("drain_sad");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
